// File: rtl/jpeg_block_gather.sv
// Raster-to-8x8-block reorder buffer: ping-pong 8-line stripe memory feeding jpeg_pipeline
// with level-shifted pixels, one 8-pixel block row per downstream ready pulse.
module jpeg_block_gather #(
    parameter int WIDTH = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_pixel,
    input  logic       ena_in,
    output logic       rdy_out,
    output logic [7:0] out_pixel,
    output logic       ena_out,
    output logic       out_sob,
    input  logic       rdy_in,
    output logic [1:0] rd_state_dbg
);
    localparam int BLKS  = WIDTH / 8;
    localparam int COL_W = $clog2(WIDTH);
    localparam int BLK_W = (BLKS > 1) ? $clog2(BLKS) : 1;
    localparam int DEPTH = 16 * WIDTH;
    localparam int AW    = $clog2(DEPTH);

    generate
        if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
            $error("jpeg_block_gather: WIDTH must be a multiple of 8 and >= 8");
        end
    endgenerate

    // Handshake: a pixel moves on a posedge where ena_in && rdy_out; downstream
    // rdy_in is sampled only while waiting and grants one whole 8-pixel burst.
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_t;

    rd_state_t        state, state_nxt;
    logic [COL_W-1:0] wcol;
    logic [2:0]       wline;
    logic             wr_bank;
    logic [1:0]       full;
    logic             rd_bank;
    logic [BLK_W-1:0] blk;
    logic [2:0]       row;
    logic [2:0]       col;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_sob;
    logic             accept;
    logic             wr_last;
    logic             burst_last;
    logic             stripe_last;

    assign rdy_out      = !rst && !full[wr_bank];
    assign accept       = ena_in && rdy_out;
    assign wr_last      = (wline == 3'd7) && (wcol == COL_W'(WIDTH - 1));
    assign burst_last   = (state == RD_BURST) && (col == 3'd7);
    assign stripe_last  = burst_last && (row == 3'd7) && (blk == BLK_W'(BLKS - 1));
    assign rd_state_dbg = state;

    // Linear layout: bank, then line, then column.
    assign waddr = AW'(int'({wr_bank, wline}) * WIDTH + int'(wcol));
    assign raddr = AW'(int'({rd_bank, row}) * WIDTH + int'(blk) * 8 + int'(col));

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[waddr] <= in_pixel;
        end
        rd_data <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcol    <= '0;
            wline   <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (wcol == COL_W'(WIDTH - 1)) begin
                wcol  <= '0;
                wline <= wline + 3'd1;
                if (wline == 3'd7) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                wcol <= wcol + COL_W'(1);
            end
        end
    end

    // Writer only fills a non-full bank and reader only drains a full one, so
    // the set and clear can never target the same flag in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (accept && wr_last) begin
                full[wr_bank] <= 1'b1;
            end
            if (stripe_last) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_bank <= 1'b0;
            blk     <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            state <= state_nxt;
            if (state == RD_BURST) begin
                col <= col + 3'd1;
                if (col == 3'd7) begin
                    row <= row + 3'd1;
                    if (row == 3'd7) begin
                        blk <= (blk == BLK_W'(BLKS - 1)) ? '0 : blk + BLK_W'(1);
                    end
                end
            end
            if (stripe_last) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:  if (full[rd_bank]) state_nxt = RD_WAIT;
            RD_WAIT:  if (rdy_in) state_nxt = RD_BURST;
            RD_BURST: if (burst_last) state_nxt = stripe_last ? RD_IDLE : RD_WAIT;
            default:  state_nxt = RD_IDLE;
        endcase
    end

    // Two-stage output: RAM read register, then level-shifted output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_sob    <= 1'b0;
            ena_out   <= 1'b0;
            out_sob   <= 1'b0;
            out_pixel <= 8'h00;
        end else begin
            rd_valid  <= (state == RD_BURST);
            rd_sob    <= (state == RD_BURST) && (col == 3'd0) && (row == 3'd0);
            ena_out   <= rd_valid;
            out_sob   <= rd_sob;
            out_pixel <= rd_valid ? {~rd_data[7], rd_data[6:0]} : 8'h00;
        end
    end
endmodule

// File: tb/tb_jpeg_block_gather.sv
// Directed bench for jpeg_block_gather at WIDTH=16: reset, ramp, level shift,
// backpressure, ping-pong and mid-burst reset, with an expected-output queue.
module tb_jpeg_block_gather;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_pixel;
    logic       ena_in;
    logic       rdy_out;
    logic [7:0] out_pixel;
    logic       ena_out;
    logic       out_sob;
    logic       rdy_in;
    logic [1:0] rd_state_dbg;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ena_cnt = 0;
    int         sob_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e_mon;

    jpeg_block_gather #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .ena_in(ena_in), .rdy_out(rdy_out),
        .out_pixel(out_pixel), .ena_out(ena_out), .out_sob(out_sob), .rdy_in(rdy_in),
        .rd_state_dbg(rd_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entry is {sob, pixel}.
    always @(negedge clk) begin
        if (ena_out === 1'b1) begin
            ena_cnt++;
            if (out_sob === 1'b1) sob_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_ena_out", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("out_sob_pixel", {23'd0, out_sob, out_pixel}, {23'd0, e_mon});
            end
        end
    end

    // mode 0: ramp base + line*16 + col; mode 1: level-shift corner values, rest 0x55.
    function automatic logic [7:0] pix_val(input int mode, input int base, input int l, input int c);
        if (mode == 0) return 8'(base + l * 16 + c);
        if (l == 0 && c == 0) return 8'd0;
        if (l == 0 && c == 1) return 8'd127;
        if (l == 0 && c == 2) return 8'd128;
        if (l == 0 && c == 3) return 8'd255;
        return 8'h55;
    endfunction

    function automatic logic [7:0] exp_val(input int mode, input int base, input int l, input int c);
        if (mode == 0) return 8'(base + l * 16 + c - 128);
        if (l == 0 && c == 0) return 8'h80;
        if (l == 0 && c == 1) return 8'hFF;
        if (l == 0 && c == 2) return 8'h00;
        if (l == 0 && c == 3) return 8'h7F;
        return 8'hD5;
    endfunction

    task automatic push_stripe(input int mode, input int base);
        for (int b = 0; b < W / 8; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    exp_q.push_back({(r == 0 && c == 0), exp_val(mode, base, r, b * 8 + c)});
    endtask

    task automatic send_pixel(input logic [7:0] p);
        int t = 0;
        @(negedge clk);
        while (!rdy_out && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_out) begin
            check("send_timeout", 32'd0, 32'd1);
            return;
        end
        ena_in   = 1'b1;
        in_pixel = p;
        @(posedge clk);
        #1;
        ena_in = 1'b0;
    endtask

    task automatic load_stripe(input int mode, input int base);
        for (int l = 0; l < 8; l++)
            for (int c = 0; c < W; c++)
                send_pixel(pix_val(mode, base, l, c));
    endtask

    task automatic wait_drain(input int max_cycles, input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
        check(tag, exp_q.size(), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int s0;
        int idx;
        int cnt;
        int t;
        bit seen;
        bit acc;

        rst      = 1'b1;
        ena_in   = 1'b1;
        in_pixel = 8'hAA;
        rdy_in   = 1'b0;

        // Reset held with ena_in high: nothing accepted, outputs quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rdy_out", rdy_out, 32'd0);
            check("rst_ena_out", ena_out, 32'd0);
            check("rst_out_pixel", out_pixel, 32'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ena_in = 1'b0;
        @(negedge clk);
        check("rdy_out_after_rst", rdy_out, 32'd1);

        // Ramp stripe, downstream always ready.
        rdy_in = 1'b1;
        e0 = ena_cnt;
        s0 = sob_cnt;
        push_stripe(0, 0);
        load_stripe(0, 0);
        wait_drain(400, "drain_ramp");
        check("ramp_pixel_count", ena_cnt - e0, 32'd128);
        check("ramp_sob_count", sob_cnt - s0, 32'd2);

        // Level-shift corner values.
        push_stripe(1, 0);
        load_stripe(1, 0);
        wait_drain(400, "drain_level");

        // Backpressure: loaded stripe stays silent, then a 1-cycle ready pulse.
        rdy_in = 1'b0;
        push_stripe(0, 0);
        load_stripe(0, 0);
        e0 = ena_cnt;
        repeat (50) @(negedge clk);
        check("bp_silent", ena_cnt - e0, 32'd0);
        rdy_in = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) rdy_in = 1'b0;
            check("bp_pulse_ena", ena_out, 32'((i >= 3) && (i <= 10)));
        end
        check("bp_pulse_count", ena_cnt - e0, 32'd8);
        rdy_in = 1'b1;
        wait_drain(400, "drain_bp");

        // Ping-pong: three stripes streamed against a stalled reader.
        rdy_in = 1'b0;
        for (int s = 0; s < 3; s++) push_stripe(0, s * 32);
        e0  = ena_cnt;
        idx = 0;
        repeat (300) begin
            @(negedge clk);
            acc      = rdy_out && (idx < 384);
            ena_in   = acc;
            in_pixel = acc ? pix_val(0, (idx / 128) * 32, (idx % 128) / 16, idx % 16) : 8'h00;
            @(posedge clk);
            #1;
            if (acc) idx++;
            ena_in = 1'b0;
        end
        check("pp_accepted_stalled", idx, 32'd256);
        @(negedge clk);
        check("pp_rdy_out_low", rdy_out, 32'd0);
        check("pp_no_output", ena_cnt - e0, 32'd0);
        rdy_in = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        t    = 0;
        while ((idx < 384 || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
            if (ena_out) cnt++;
            // Bank0 frees on the edge issuing its last read; by then 127 pixels have shown.
            if (!seen && rdy_out) begin
                seen = 1'b1;
                check("pp_rdy_rise_after_bank0", cnt, 32'd127);
            end
            acc      = rdy_out && (idx < 384);
            ena_in   = acc;
            in_pixel = acc ? pix_val(0, (idx / 128) * 32, (idx % 128) / 16, idx % 16) : 8'h00;
            @(posedge clk);
            #1;
            if (acc) idx++;
            ena_in = 1'b0;
        end
        check("pp_rdy_rose", seen, 32'd1);
        check("pp_all_accepted", idx, 32'd384);
        check("pp_total_pixels", cnt, 32'd384);
        wait_drain(100, "drain_pp");

        // Reset during the 4th output pixel of a burst.
        rdy_in = 1'b0;
        push_stripe(0, 0);
        load_stripe(0, 0);
        rdy_in = 1'b1;
        cnt = 0;
        t   = 0;
        while (cnt < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (ena_out) cnt++;
        end
        check("rst_mid_reached_4th", cnt, 32'd4);
        rst    = 1'b1;
        rdy_in = 1'b0;
        @(negedge clk);
        check("rst_mid_ena_out", ena_out, 32'd0);
        check("rst_mid_out_sob", out_sob, 32'd0);
        check("rst_mid_out_pixel", out_pixel, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rdy_out", rdy_out, 32'd1);
        rdy_in = 1'b1;
        e0 = ena_cnt;
        s0 = sob_cnt;
        push_stripe(0, 0);
        load_stripe(0, 0);
        wait_drain(400, "drain_after_rst");
        check("after_rst_pixel_count", ena_cnt - e0, 32'd128);
        check("after_rst_sob_count", sob_cnt - s0, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
